// File: rtl/writeback_unit.sv
// Writeback stage: in-order result buffer that drains into the integer or float
// register-file write port, plus a per-register pending-write scoreboard.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iVALID,
    output logic                     oREADY,
    input  logic [6:0]               iOPCODE,
    input  logic [4:0]               iRD,
    input  logic                     iFP,
    input  logic [31:0]              iRESULT,
    output logic                     oRF_WE,
    output logic [4:0]               oRF_WADDR,
    output logic [31:0]              oRF_WDATA,
    input  logic                     iRF_STALL,
    output logic                     oFRF_WE,
    output logic [4:0]               oFRF_WADDR,
    output logic [31:0]              oFRF_WDATA,
    input  logic                     iFRF_STALL,
    input  logic                     iISSUE,
    input  logic [4:0]               iISSUE_RD,
    input  logic                     iISSUE_FP,
    output logic [31:0]              oPEND_INT,
    output logic [31:0]              oPEND_FP,
    output logic [$clog2(DEPTH):0]   oCOUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [AW-1:0] ONE_P    = AW'(1);
    localparam logic [6:0]    OP_STORE  = 7'b0100011;
    localparam logic [6:0]    OP_BRANCH = 7'b1100011;

    logic [4:0]    mem_rd   [DEPTH];
    logic          mem_fp   [DEPTH];
    logic [31:0]   mem_data [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pend_int_q, pend_int_d;
    logic [31:0]   pend_fp_q, pend_fp_d;

    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [4:0]    head_rd_s;
    logic          head_fp_s;
    logic [31:0]   head_data_s;

    assign oREADY    = (count_q < FULL_C);
    assign oCOUNT    = count_q;
    assign oPEND_INT = pend_int_q;
    assign oPEND_FP  = pend_fp_q;

    // Head decode: route the oldest entry to its port and decide whether it retires.
    always_comb begin
        empty_s     = (count_q == '0);
        head_rd_s   = mem_rd[head_q];
        head_fp_s   = mem_fp[head_q];
        head_data_s = mem_data[head_q];
        oRF_WE      = 1'b0;
        oRF_WADDR   = 5'd0;
        oRF_WDATA   = 32'd0;
        oFRF_WE     = 1'b0;
        oFRF_WADDR  = 5'd0;
        oFRF_WDATA  = 32'd0;
        pop_s       = 1'b0;
        if (empty_s) begin
            pop_s = 1'b0;
        end else if (head_fp_s) begin
            oFRF_WE    = !iFRF_STALL;
            oFRF_WADDR = head_rd_s;
            oFRF_WDATA = head_data_s;
            pop_s      = !iFRF_STALL;
        end else if (head_rd_s == 5'd0) begin
            // x0 writes are dropped but still have to leave the buffer.
            oRF_WADDR = head_rd_s;
            oRF_WDATA = head_data_s;
            pop_s     = 1'b1;
        end else begin
            oRF_WE    = !iRF_STALL;
            oRF_WADDR = head_rd_s;
            oRF_WDATA = head_data_s;
            pop_s     = !iRF_STALL;
        end
    end

    // Pointer and occupancy update.
    always_comb begin
        push_s  = iVALID && oREADY && (iOPCODE != OP_STORE) && (iOPCODE != OP_BRANCH);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_s) begin
            tail_d = tail_q + ONE_P;
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + ONE_P;
        end else begin
            head_d = head_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + ONE_C;
        end else if (pop_s && !push_s) begin
            count_d = count_q - ONE_C;
        end else begin
            count_d = count_q;
        end
    end

    // Scoreboard: clear on commit first, so a same-cycle issue to that register wins.
    always_comb begin
        pend_int_d = pend_int_q;
        pend_fp_d  = pend_fp_q;
        if (oRF_WE) begin
            pend_int_d[oRF_WADDR] = 1'b0;
        end else begin
            pend_int_d = pend_int_d;
        end
        if (oFRF_WE) begin
            pend_fp_d[oFRF_WADDR] = 1'b0;
        end else begin
            pend_fp_d = pend_fp_d;
        end
        if (iISSUE && iISSUE_FP) begin
            pend_fp_d[iISSUE_RD] = 1'b1;
        end else if (iISSUE && (iISSUE_RD != 5'd0)) begin
            pend_int_d[iISSUE_RD] = 1'b1;
        end else begin
            pend_fp_d = pend_fp_d;
        end
        pend_int_d[0] = 1'b0;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_int_q <= 32'd0;
            pend_fp_q  <= 32'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pend_int_q <= pend_int_d;
            pend_fp_q  <= pend_fp_d;
        end
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge iCLK) begin
        if (push_s && !iRST) begin
            mem_rd[tail_q]   <= iRD;
            mem_fp[tail_q]   <= iFP;
            mem_data[tail_q] <= iRESULT;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued at stimulus time
// and a negedge monitor retires them against the DUT write ports.
module tb_writeback_unit;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iVALID;
    logic        oREADY;
    logic [6:0]  iOPCODE;
    logic [4:0]  iRD;
    logic        iFP;
    logic [31:0] iRESULT;
    logic        oRF_WE;
    logic [4:0]  oRF_WADDR;
    logic [31:0] oRF_WDATA;
    logic        iRF_STALL;
    logic        oFRF_WE;
    logic [4:0]  oFRF_WADDR;
    logic [31:0] oFRF_WDATA;
    logic        iFRF_STALL;
    logic        iISSUE;
    logic [4:0]  iISSUE_RD;
    logic        iISSUE_FP;
    logic [31:0] oPEND_INT;
    logic [31:0] oPEND_FP;
    logic [2:0]  oCOUNT;

    int checks = 0;
    int failures = 0;
    logic [37:0] exp_q[$];

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    writeback_unit #(.DEPTH(4)) dut (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(oREADY),
        .iOPCODE(iOPCODE), .iRD(iRD), .iFP(iFP), .iRESULT(iRESULT),
        .oRF_WE(oRF_WE), .oRF_WADDR(oRF_WADDR), .oRF_WDATA(oRF_WDATA), .iRF_STALL(iRF_STALL),
        .oFRF_WE(oFRF_WE), .oFRF_WADDR(oFRF_WADDR), .oFRF_WDATA(oFRF_WDATA), .iFRF_STALL(iFRF_STALL),
        .iISSUE(iISSUE), .iISSUE_RD(iISSUE_RD), .iISSUE_FP(iISSUE_FP),
        .oPEND_INT(oPEND_INT), .oPEND_FP(oPEND_FP), .oCOUNT(oCOUNT)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write seen on either port must match the oldest expected write.
    always @(negedge iCLK) begin
        if (oRF_WE === 1'b1 && oFRF_WE === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL dual_we: got both ports writing expected one");
        end
        if (oRF_WE === 1'b1 || oFRF_WE === 1'b1) begin
            logic [37:0] act;
            act = oRF_WE ? {1'b0, oRF_WADDR, oRF_WDATA} : {1'b1, oFRF_WADDR, oFRF_WDATA};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got %h expected none", act);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL write_order: got %h expected %h", act, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push(input logic [6:0] op, input logic [4:0] rd, input logic fp, input logic [31:0] d);
        iVALID = 1'b1; iOPCODE = op; iRD = rd; iFP = fp; iRESULT = d;
        if (op != OP_STORE && op != 7'b1100011 && (fp || rd != 5'd0))
            exp_q.push_back({fp, rd, d});
        tick();
        iVALID = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic fp);
        iISSUE = 1'b1; iISSUE_RD = rd; iISSUE_FP = fp;
        tick();
        iISSUE = 1'b0;
    endtask

    initial begin
        iRST = 1'b1; iVALID = 1'b0; iOPCODE = 7'd0; iRD = 5'd0; iFP = 1'b0; iRESULT = 32'd0;
        iRF_STALL = 1'b0; iFRF_STALL = 1'b0; iISSUE = 1'b0; iISSUE_RD = 5'd0; iISSUE_FP = 1'b0;
        tick(); tick();
        iRST = 1'b0;
        @(negedge iCLK);
        check("rst_count", 64'(oCOUNT), 64'd0);
        check("rst_ready", 64'(oREADY), 64'd1);
        check("rst_we", 64'({oRF_WE, oFRF_WE}), 64'd0);
        check("rst_pend", 64'({oPEND_INT, oPEND_FP}), 64'd0);
        tick();

        // Single result with pending bit set then cleared.
        issue(5'd5, 1'b0);
        @(negedge iCLK);
        check("pend5_set", 64'(oPEND_INT[5]), 64'd1);
        tick();
        push(OP_ALU, 5'd5, 1'b0, 32'hDEADBEEF);
        @(negedge iCLK);
        check("single_we", 64'(oRF_WE), 64'd1);
        check("pend5_during", 64'(oPEND_INT[5]), 64'd1);
        tick();
        @(negedge iCLK);
        check("pend5_clear", 64'(oPEND_INT[5]), 64'd0);
        check("single_count", 64'(oCOUNT), 64'd0);
        tick();

        // Fill under stall, then drain in order.
        iRF_STALL = 1'b1;
        for (int i = 1; i <= 4; i++) push(OP_ALU, 5'(i), 1'b0, 32'h1000 + 32'(i));
        @(negedge iCLK);
        check("full_count", 64'(oCOUNT), 64'd4);
        check("full_ready", 64'(oREADY), 64'd0);
        check("full_we", 64'(oRF_WE), 64'd0);
        tick();
        iRF_STALL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            check("drain_we", 64'(oRF_WE), 64'd1);
            if (i == 1) check("drain_ready", 64'(oREADY), 64'd1);
            tick();
        end
        @(negedge iCLK);
        check("drain_empty", 64'(oCOUNT), 64'd0);
        tick();

        // Filtering: x0 int dropped, store discarded, float f0 written.
        push(OP_STORE, 5'd9, 1'b0, 32'h12345678);
        @(negedge iCLK);
        check("store_not_queued", 64'(oCOUNT), 64'd0);
        tick();
        push(OP_ALU, 5'd0, 1'b0, 32'hAAAA5555);
        push(OP_STORE, 5'd9, 1'b0, 32'h12345678);
        push(OP_ALU, 5'd0, 1'b1, 32'h3F800000);
        @(negedge iCLK);
        check("f0_we", 64'(oFRF_WE), 64'd1);
        check("f0_addr", 64'(oFRF_WADDR), 64'd0);
        check("f0_data", 64'(oFRF_WDATA), 64'h3F800000);
        tick();

        // Continuous push with simultaneous pop keeps occupancy at one.
        for (int i = 0; i < 6; i++) begin
            push(OP_ALU, 5'(20 + i), 1'b0, 32'hC0DE0000 + 32'(i));
            @(negedge iCLK);
            check("stream_count", 64'(oCOUNT), 64'd1);
        end
        tick();

        // Mixed ports: stalled int head blocks the float entry behind it.
        iRF_STALL = 1'b1;
        push(OP_ALU, 5'd10, 1'b0, 32'hA0A0A0A0);
        push(OP_ALU, 5'd11, 1'b1, 32'hB0B0B0B0);
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check("mix_hold", 64'({oRF_WE, oFRF_WE, oRF_WADDR, oFRF_WADDR}), 64'({1'b0, 1'b0, 5'd10, 5'd0}));
            check("mix_data", 64'({oRF_WDATA, oFRF_WDATA}), 64'({32'hA0A0A0A0, 32'd0}));
            tick();
        end
        iRF_STALL = 1'b0;
        tick(); tick();
        @(negedge iCLK);
        check("mix_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Scoreboard race: commit to x7 in the same cycle as a new issue to x7.
        issue(5'd7, 1'b0);
        push(OP_ALU, 5'd7, 1'b0, 32'h77777777);
        iISSUE = 1'b1; iISSUE_RD = 5'd7; iISSUE_FP = 1'b0;
        @(negedge iCLK);
        check("race_we", 64'(oRF_WE), 64'd1);
        tick();
        iISSUE = 1'b0;
        @(negedge iCLK);
        check("race_pend7", 64'(oPEND_INT[7]), 64'd1);
        issue(5'd0, 1'b0);
        issue(5'd3, 1'b1);
        @(negedge iCLK);
        check("pend_x0", 64'(oPEND_INT[0]), 64'd0);
        check("pend_f3", 64'(oPEND_FP[3]), 64'd1);
        push(OP_ALU, 5'd3, 1'b1, 32'h40490FDB);
        tick();
        @(negedge iCLK);
        check("pend_f3_clear", 64'(oPEND_FP[3]), 64'd0);
        tick();

        // Reset mid-operation drops queued entries and pending bits.
        iRF_STALL = 1'b1;
        for (int i = 0; i < 3; i++) push(OP_ALU, 5'(12 + i), 1'b0, 32'hBAD00000 + 32'(i));
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        iRF_STALL = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check("rst2_count", 64'(oCOUNT), 64'd0);
            check("rst2_ready", 64'(oREADY), 64'd1);
            check("rst2_we", 64'({oRF_WE, oFRF_WE}), 64'd0);
            check("rst2_pend", 64'({oPEND_INT, oPEND_FP}), 64'd0);
            tick();
        end

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-buffer entries (power of two, 2..16).
REQ-002 SHALL have ports iCLK in 1 (single clock, rising edge) and iRST in 1 (reset, synchronous, active-high).
REQ-003 SHALL have iVALID in 1 (ALU result offered), oREADY out 1 (result accepted this cycle when high with iVALID).
REQ-004 SHALL have iOPCODE in 7 (opcode of the producing instruction), iRD in 5 (destination index), iFP in 1 (1 = float register file target), iRESULT in 32 (ALU output value).
REQ-005 SHALL have oRF_WE out 1, oRF_WADDR out 5, oRF_WDATA out 32 (integer register-file write port) and iRF_STALL in 1 (integer port unavailable this cycle).
REQ-006 SHALL have oFRF_WE out 1, oFRF_WADDR out 5, oFRF_WDATA out 32 (float register-file write port) and iFRF_STALL in 1 (float port unavailable this cycle).
REQ-007 SHALL have iISSUE in 1, iISSUE_RD in 5, iISSUE_FP in 1 (issue side announces a pending destination).
REQ-008 SHALL have oPEND_INT out 32 and oPEND_FP out 32 (per-register pending-write scoreboard) and oCOUNT out log2(DEPTH)+1 (buffer occupancy).

Function
REQ-009 SHALL assert oREADY = (oCOUNT < DEPTH), independent of same-cycle pops.
REQ-010 SHALL, on iVALID & oREADY, enqueue {iRD, iFP, iRESULT} at the tail, except opcodes 0100011 (store) and 1100011 (branch), which are accepted and discarded with no enqueue.
REQ-011 SHALL drive the write ports combinationally from the head entry; an entry enqueued at edge N is visible at the port in cycle N+1 at earliest.
REQ-012 SHALL, for an integer head with rd != 0, assert oRF_WE = !iRF_STALL, with oRF_WADDR = rd, oRF_WDATA = result; pop when oRF_WE is high.
REQ-013 SHALL, for an integer head with rd == 0, hold oRF_WE low and pop in that cycle regardless of iRF_STALL.
REQ-014 SHALL, for a float head, assert oFRF_WE = !iFRF_STALL (rd 0 is a valid float target); pop when oFRF_WE is high.
REQ-015 SHALL pop at most one entry per cycle; while stalled, the head and the port address/data outputs SHALL be held stable.
REQ-016 SHALL drive WE low and WADDR/WDATA to 0 on both ports when the buffer is empty and on the port not targeted by the head.
REQ-017 SHALL, on simultaneous push and pop, keep oCOUNT unchanged and preserve FIFO order; head/tail pointers SHALL wrap modulo DEPTH.
REQ-018 SHALL set oPEND_INT[iISSUE_RD] on iISSUE & !iISSUE_FP & iISSUE_RD != 0, and oPEND_FP[iISSUE_RD] on iISSUE & iISSUE_FP; oPEND_INT[0] SHALL always read 0.
REQ-019 SHALL clear the matching pending bit on the edge following the cycle in which the corresponding WE is high.
REQ-020 SHALL, when set and clear hit the same bit in the same cycle, leave the bit set (newer issue wins).
REQ-021 SHALL treat iISSUE as independent of iVALID; no checking of issue/result pairing.

Reset
REQ-022 SHALL, on iRST high at a rising edge, empty the buffer (oCOUNT = 0, pointers 0), clear oPEND_INT and oPEND_FP to 0, leaving oREADY = 1 and both WE low in the following cycle.
REQ-023 SHALL give iRST priority over any same-cycle push, pop, issue or clear; entries present at reset SHALL be lost without write.
REQ-024 SHALL leave buffer data storage unreset; only valid state is reset.

Verification
REQ-025 Single result: issue rd=5 int, then iVALID opcode 0110011 rd=5 data 0xDEADBEEF -> next cycle oRF_WE=1, WADDR=5, WDATA=0xDEADBEEF; oPEND_INT[5] 1 then 0.
REQ-026 Fill/stall: iRF_STALL=1, push 4 int results -> oCOUNT=4, oREADY=0, WE low; release stall -> 4 writes in order over 4 consecutive cycles, oREADY=1 after the first pop.
REQ-027 Filtering: push rd=0 int, opcode 0100011, and float rd=0 data 0x3F800000 -> no integer write, store not enqueued, oFRF_WE=1 with WADDR=0, WDATA=0x3F800000.
REQ-028 Mixed ports: int head with iRF_STALL=1 and float entry behind -> float not written until int pops (in-order); outputs held stable throughout the stall.
REQ-029 Scoreboard race: rd=7 int write commits in the same cycle as a new iISSUE rd=7 -> oPEND_INT[7] remains 1.
REQ-030 Reset mid-operation: 3 entries queued with stall, assert iRST -> oCOUNT=0, all pending bits 0, no write issued after release.
